// File: rtl/change_dispenser_ctrl.sv
// change_dispenser_ctrl: coin payout sequencer with tube inventories and ejector req/ack handshake
module change_dispenser_ctrl #(
  parameter int AMT_W        = 10,
  parameter int CNT_W        = 6,
  parameter int TUBE_MAX     = 50,
  parameter int INIT_DOLLAR  = 10,
  parameter int INIT_QUARTER = 20,
  parameter int INIT_DIME    = 20,
  parameter int ACK_TIMEOUT  = 255,
  parameter int SETTLE_CYC   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             eject_ack,
  input  logic             refill_d,
  input  logic             refill_q,
  input  logic             refill_m,
  output logic             eject_req,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             short_pay,
  output logic             jam,
  output logic [AMT_W-1:0] residual,
  output logic [CNT_W-1:0] cnt_dollar,
  output logic [CNT_W-1:0] cnt_quarter,
  output logic [CNT_W-1:0] cnt_dime
);
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, SETTLE, FINISH, JAM} state_t;
  localparam int TW = $clog2((ACK_TIMEOUT > SETTLE_CYC ? ACK_TIMEOUT : SETTLE_CYC) + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(TUBE_MAX);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(100);
  localparam logic [AMT_W-1:0] V_H = AMT_W'(50);
  localparam logic [AMT_W-1:0] V_Q = AMT_W'(25);
  localparam logic [AMT_W-1:0] V_M = AMT_W'(10);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(5);
  state_t state, state_n;
  logic [AMT_W-1:0] rem, rem_n, val;
  logic [1:0] sel, sel_n;
  logic [TW-1:0] tmr;
  logic acked;
  logic [3:1] refill;
  assign acked = state == EJECT && eject_ack;
  assign refill = {refill_d, refill_q, refill_m};
  assign val = sel == 2'd3 ? V_D : sel == 2'd2 ? V_Q : V_M;
  always_comb begin
    state_n = state;
    rem_n = rem;
    sel_n = sel;
    case (state)
      IDLE: if (start) begin
        state_n = SELECT;
        rem_n = change_amt;
      end
      SELECT: begin
        state_n = EJECT;
        if (rem == '0) state_n = FINISH;
        else if (rem >= V_D && cnt_dollar != '0) sel_n = 2'd3;
        else if (rem >= V_Q && cnt_quarter != '0 && (rem >= V_H || rem % V_M == V_N)) sel_n = 2'd2;
        else if (rem >= V_M && cnt_dime != '0) sel_n = 2'd1;
        else state_n = FINISH;
      end
      EJECT: if (eject_ack) begin
        state_n = SETTLE;
        rem_n = rem - val;
      end else if (tmr == TW'(ACK_TIMEOUT - 1)) state_n = JAM;
      SETTLE: if (tmr == TW'(SETTLE_CYC - 1)) state_n = SELECT;
      FINISH: state_n = IDLE;
      default: state_n = JAM;
    endcase
  end
  // the timer restarts on every state change, so it measures time spent in EJECT or SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      sel <= '0;
      tmr <= '0;
      residual <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      sel <= sel_n;
      tmr <= state_n != state ? '0 : tmr + TW'(1);
      if (state_n != state && (state_n == FINISH || state_n == JAM)) residual <= rem_n;
    end
  end
  for (genvar t = 1; t <= 3; t++) begin : g_tube
    localparam int INIT = t == 3 ? INIT_DOLLAR : t == 2 ? INIT_QUARTER : INIT_DIME;
    localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT > TUBE_MAX ? TUBE_MAX : INIT);
    logic [CNT_W-1:0] c;
    logic dec;
    assign dec = acked && sel == 2'(t);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= INIT_C;
      else if (dec && !refill[t]) c <= c - CNT_W'(1);
      else if (!dec && refill[t] && c < MAX_C) c <= c + CNT_W'(1);
    end
  end
  assign cnt_dime = g_tube[1].c;
  assign cnt_quarter = g_tube[2].c;
  assign cnt_dollar = g_tube[3].c;
  assign eject_req = state == EJECT;
  assign coin_sel = state == EJECT ? sel : 2'd0;
  assign busy = state inside {SELECT, EJECT, SETTLE, FINISH};
  assign done = state == FINISH && rem == '0;
  assign short_pay = state == FINISH && rem != '0;
  assign jam = state == JAM;
endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// tb_change_dispenser_ctrl: scoreboard bench; expected coins queued at start, popped on each eject_req
module tb_change_dispenser_ctrl;
  logic clk = 0, rst_n = 0, start = 0, start0 = 0, eject_ack = 0;
  logic refill_d = 0, refill_q = 0, refill_m = 0;
  logic [9:0] change_amt = '0;
  logic eject_req, busy, done, short_pay, jam;
  logic [1:0] coin_sel;
  logic [9:0] residual;
  logic [5:0] cnt_dollar, cnt_quarter, cnt_dime;
  logic req0, busy0, done0, short0, jam0;
  logic [1:0] sel0;
  logic [9:0] res0;
  logic [5:0] cd0, cq0, cm0;
  int checks = 0, errors = 0, exp_d, exp_q, exp_m;
  logic [1:0] q_coin[$];

  always #5 clk = ~clk;

  change_dispenser_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .change_amt(change_amt), .eject_ack(eject_ack),
    .refill_d(refill_d), .refill_q(refill_q), .refill_m(refill_m), .eject_req(eject_req),
    .coin_sel(coin_sel), .busy(busy), .done(done), .short_pay(short_pay), .jam(jam),
    .residual(residual), .cnt_dollar(cnt_dollar), .cnt_quarter(cnt_quarter), .cnt_dime(cnt_dime)
  );

  change_dispenser_ctrl #(.INIT_DIME(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .change_amt(change_amt), .eject_ack(1'b0),
    .refill_d(1'b0), .refill_q(1'b0), .refill_m(1'b0), .eject_req(req0),
    .coin_sel(sel0), .busy(busy0), .done(done0), .short_pay(short0), .jam(jam0),
    .residual(res0), .cnt_dollar(cd0), .cnt_quarter(cq0), .cnt_dime(cm0)
  );

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_d = 10; exp_q = 20; exp_m = 20;
  endtask

  task automatic payout(input logic [9:0] amt, input int dly, input bit exp_ok,
                        input logic [9:0] exp_res, input bit rq, input bit poke);
    int cyc, last;
    bit first;
    logic [1:0] c;
    first = 1; cyc = 0; last = 0;
    @(negedge clk); change_amt = amt; start = 1;
    @(negedge clk); start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start amt=%0d got %b want 1", amt, busy); end
    while (!(done === 1'b1 || short_pay === 1'b1) && cyc < 4000) begin
      if (eject_req === 1'b1) begin
        checks++;
        if (first && cyc != 1) begin errors++; $display("FAIL req_latency amt=%0d got %0d want 1", amt, cyc); end
        else if (!first && cyc - last != 4) begin errors++; $display("FAIL settle_gap amt=%0d got %0d want 4", amt, cyc - last); end
        first = 0;
        checks++;
        if (q_coin.size() == 0) begin
          c = 2'd0; errors++; $display("FAIL extra_coin amt=%0d got coin %0d want none", amt, coin_sel);
        end else begin
          c = q_coin.pop_front();
          if (coin_sel !== c) begin errors++; $display("FAIL coin_sel amt=%0d got %0d want %0d", amt, coin_sel, c); end
        end
        if (c == 2'd3) exp_d--;
        if (c == 2'd2) exp_q--;
        if (c == 2'd1) exp_m--;
        if (rq && exp_q < 50) exp_q++;
        repeat (dly) @(negedge clk);
        eject_ack = 1; refill_q = rq;
        if (poke) begin start = 1; change_amt = '0; end
        poke = 0;
        @(negedge clk);
        eject_ack = 0; refill_q = 0; start = 0;
        cyc++;
        last = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (cyc >= 4000) begin errors++; $display("FAIL payout_timeout amt=%0d got no finish want done/short", amt); end
    checks++;
    if (done !== exp_ok || short_pay !== !exp_ok) begin
      errors++; $display("FAIL outcome amt=%0d got done=%b short=%b want done=%b", amt, done, short_pay, exp_ok);
    end
    checks++;
    if (residual !== exp_res) begin errors++; $display("FAIL residual amt=%0d got %0d want %0d", amt, residual, exp_res); end
    checks++;
    if (q_coin.size() != 0) begin errors++; $display("FAIL missing_coins amt=%0d got %0d left want 0", amt, q_coin.size()); end
    q_coin.delete();
    checks++;
    if ({cnt_dollar, cnt_quarter, cnt_dime} !== {6'(exp_d), 6'(exp_q), 6'(exp_m)}) begin
      errors++; $display("FAIL counts amt=%0d got %0d/%0d/%0d want %0d/%0d/%0d", amt,
                         cnt_dollar, cnt_quarter, cnt_dime, exp_d, exp_q, exp_m);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || short_pay !== 1'b0 || residual !== exp_res) begin
      errors++; $display("FAIL idle_after amt=%0d got busy=%b done=%b short=%b res=%0d want 0/0/0/%0d",
                         amt, busy, done, short_pay, residual, exp_res);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({eject_req, coin_sel, busy, done, short_pay, jam} !== 7'b0 || residual !== 10'd0) begin
      errors++; $display("FAIL reset_outputs got req=%b sel=%0d busy=%b done=%b short=%b jam=%b res=%0d want all 0",
                         eject_req, coin_sel, busy, done, short_pay, jam, residual);
    end
    checks++;
    if ({cnt_dollar, cnt_quarter, cnt_dime} !== {6'd10, 6'd20, 6'd20}) begin
      errors++; $display("FAIL reset_counts got %0d/%0d/%0d want 10/20/20", cnt_dollar, cnt_quarter, cnt_dime);
    end
  endtask

  task automatic test_full_pay();
    q_coin = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd1};
    payout(10'd185, 2, 1, 10'd0, 0, 0);
    checks++;
    if ({cnt_dollar, cnt_quarter, cnt_dime} !== {6'd9, 6'd17, 6'd19}) begin
      errors++; $display("FAIL t1_counts got %0d/%0d/%0d want 9/17/19", cnt_dollar, cnt_quarter, cnt_dime);
    end
  endtask

  task automatic test_quarter_rule();
    q_coin = '{2'd1, 2'd1, 2'd1};
    payout(10'd30, 1, 1, 10'd0, 0, 0);
    q_coin = '{2'd1};
    payout(10'd15, 0, 0, 10'd5, 0, 0);
  endtask

  task automatic test_zero();
    @(negedge clk); change_amt = 10'd0; start = 1;
    @(negedge clk); start = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_c1 got busy=%b done=%b want 1/0", busy, done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || short_pay !== 1'b0 || residual !== 10'd0 || eject_req !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b short=%b res=%0d req=%b want 1/0/0/0", done, short_pay, residual, eject_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_back_to_back();
    q_coin = '{2'd1, 2'd1, 2'd1};
    payout(10'd30, 0, 1, 10'd0, 0, 1);
    q_coin = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    payout(10'd165, 0, 1, 10'd0, 0, 0);
  endtask

  task automatic test_refill();
    q_coin = '{2'd2};
    payout(10'd25, 1, 1, 10'd0, 1, 0);
    @(negedge clk); refill_d = 1;
    repeat (41) @(negedge clk);
    refill_d = 0;
    checks++;
    if (cnt_dollar !== 6'd49) begin errors++; $display("FAIL refill_count got %0d want 49", cnt_dollar); end
    refill_d = 1;
    repeat (4) @(negedge clk);
    refill_d = 0;
    checks++;
    if (cnt_dollar !== 6'd50) begin errors++; $display("FAIL refill_saturate got %0d want 50", cnt_dollar); end
  endtask

  task automatic test_no_dime();
    @(negedge clk); change_amt = 10'd40; start0 = 1;
    @(negedge clk); start0 = 0;
    checks++;
    if (busy0 !== 1'b1 || req0 !== 1'b0) begin errors++; $display("FAIL nodime_c1 got busy=%b req=%b want 1/0", busy0, req0); end
    @(negedge clk);
    checks++;
    if (short0 !== 1'b1 || done0 !== 1'b0 || res0 !== 10'd40 || req0 !== 1'b0 || cm0 !== 6'd0) begin
      errors++; $display("FAIL nodime_short got short=%b done=%b res=%0d req=%b dime=%0d want 1/0/40/0/0",
                         short0, done0, res0, req0, cm0);
    end
  endtask

  task automatic test_jam();
    @(negedge clk); change_amt = 10'd10; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    checks++;
    if (eject_req !== 1'b1 || coin_sel !== 2'd1) begin errors++; $display("FAIL jam_req got req=%b sel=%0d want 1/1", eject_req, coin_sel); end
    repeat (254) @(negedge clk);
    checks++;
    if (jam !== 1'b0 || eject_req !== 1'b1) begin errors++; $display("FAIL jam_early got jam=%b req=%b want 0/1", jam, eject_req); end
    @(negedge clk);
    checks++;
    if (jam !== 1'b1 || eject_req !== 1'b0 || busy !== 1'b0 || residual !== 10'd10) begin
      errors++; $display("FAIL jam_entry got jam=%b req=%b busy=%b res=%0d want 1/0/0/10", jam, eject_req, busy, residual);
    end
    change_amt = 10'd0; start = 1; eject_ack = 1;
    @(negedge clk); start = 0; eject_ack = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (jam !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || eject_req !== 1'b0 || cnt_dime !== 6'(exp_m)) begin
      errors++; $display("FAIL jam_sticky got jam=%b busy=%b done=%b req=%b dime=%0d want 1/0/0/0/%0d",
                         jam, busy, done, eject_req, cnt_dime, exp_m);
    end
  endtask

  task automatic test_abort();
    bit seen;
    do_reset();
    checks++;
    if (jam !== 1'b0 || cnt_dollar !== 6'd10) begin errors++; $display("FAIL jam_clear got jam=%b dollar=%0d want 0/10", jam, cnt_dollar); end
    @(negedge clk); change_amt = 10'd110; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    checks++;
    if (eject_req !== 1'b1 || coin_sel !== 2'd3) begin errors++; $display("FAIL abort_first got req=%b sel=%0d want 1/3", eject_req, coin_sel); end
    eject_ack = 1;
    @(negedge clk); eject_ack = 0;
    checks++;
    if (cnt_dollar !== 6'd9 || eject_req !== 1'b0) begin errors++; $display("FAIL abort_ack got dollar=%0d req=%b want 9/0", cnt_dollar, eject_req); end
    for (int i = 0; i < 10 && eject_req !== 1'b1; i++) @(negedge clk);
    checks++;
    if (eject_req !== 1'b1 || coin_sel !== 2'd1) begin errors++; $display("FAIL abort_second got req=%b sel=%0d want 1/1", eject_req, coin_sel); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (eject_req !== 1'b0 || busy !== 1'b0 || {cnt_dollar, cnt_quarter, cnt_dime} !== {6'd10, 6'd20, 6'd20}) begin
      errors++; $display("FAIL abort_async got req=%b busy=%b counts=%0d/%0d/%0d want 0/0/10/20/20",
                         eject_req, busy, cnt_dollar, cnt_quarter, cnt_dime);
    end
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (eject_req === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_resume got activity after reset want none"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_pay();
    test_quarter_rule();
    test_zero();
    test_back_to_back();
    test_refill();
    test_no_dime();
    test_jam();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
